// File: rtl/irq_ack_dispatch.sv
// Interrupt response stage: samples the priority encoder's bank flags and channel code,
// and runs a req/ack handshake with the CPU. It then sends a one-hot ack pulse back to the winning source.
// Optional build macro ACK_TIMEOUT_EN adds a CPU-ack watchdog and a timeout output.
module irq_ack_dispatch #(
    parameter int NCHAN   = 9,
    parameter int NBANK   = 3,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pa,
    input  logic                   pb,
    input  logic                   pc,
    input  logic [3:0]             chan,
    output logic                   irq,
    output logic [4:0]             vector,
    input  logic                   cpu_ack,
    output logic [NBANK*NCHAN-1:0] ack_onehot,
    output logic                   bad_code,
`ifdef ACK_TIMEOUT_EN
    output logic                   timeout,
`endif
    output logic                   busy
);

    localparam int NLINE  = NBANK * NCHAN;
    localparam int HOLD_W = 4;
    // An out-of-range configuration keeps the block permanently idle.
    localparam bit CFG_OK = (HOLDOFF >= 1) && (HOLDOFF <= 15) && (TIMEOUT >= 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

    state_t              r_state;
    logic                r_irq;
    logic [4:0]          r_vector;
    logic [NLINE-1:0]    r_ack;
    logic                r_bad;
    logic                r_busy;
    logic [HOLD_W-1:0]   r_hold;

    logic                w_any;
    logic                w_code_ok;
    logic [1:0]          w_bank;
    logic [4:0]          w_vec;
    logic [NLINE-1:0]    w_dec;

`ifdef ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    r_tmo;
    logic                r_timeout;
    assign timeout = r_timeout;
`endif

    assign w_any     = CFG_OK && (pa || pb || pc);
    assign w_code_ok = ({28'd0, chan} < NCHAN);

    always_comb begin
        w_bank = 2'd2;
        if (pa)
            w_bank = 2'd0;
        else if (pb)
            w_bank = 2'd1;
        w_vec = 5'(w_bank) * 5'(NCHAN) + {1'b0, chan};
    end

    // Decode of the held vector into the acknowledge line pattern.
    generate
        for (genvar gi = 0; gi < NLINE; gi++) begin : g_dec
            assign w_dec[gi] = (r_vector == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_vector <= 5'd0;
            r_ack    <= '0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_hold   <= '0;
`ifdef ACK_TIMEOUT_EN
            r_tmo     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
`ifdef ACK_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        if (w_code_ok) begin
                            r_vector <= w_vec;
                            r_irq    <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= REQ;
`ifdef ACK_TIMEOUT_EN
                            r_tmo    <= TMO_W'(1);
`endif
                        end else begin
                            r_bad <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (cpu_ack) begin
                        r_irq   <= 1'b0;
                        r_ack   <= w_dec;
                        r_state <= ACK;
                    end
`ifdef ACK_TIMEOUT_EN
                    // Expiry sends the source through holdoff so it can re-request.
                    else if (r_tmo == TMO_W'(TIMEOUT)) begin
                        r_irq     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_hold    <= HOLD_W'(HOLDOFF);
                        r_state   <= HOLD;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
`endif
                end
                ACK: begin
                    r_hold  <= HOLD_W'(HOLDOFF);
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (r_hold <= HOLD_W'(1)) begin
                        r_hold  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign irq        = r_irq;
    assign vector     = r_vector;
    assign ack_onehot = r_ack;
    assign bad_code   = r_bad;
    assign busy       = r_busy;

endmodule

// File: tb/tb_irq_ack_dispatch.sv
// Scoreboard bench for irq_ack_dispatch: expected vectors are queued when a request is driven
// and popped when the DUT raises irq / pulses the acknowledge line.
module tb_irq_ack_dispatch;

    localparam int HOLD = 2;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pa = 1'b0, pb = 1'b0, pc = 1'b0, cpu_ack = 1'b0;
    logic [3:0]  chan = 4'd0;
    logic        irq, bad_code, busy;
    logic [4:0]  vector;
    logic [26:0] ack_onehot;
`ifdef ACK_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int q_exp[$];

    irq_ack_dispatch #(.NCHAN(9), .NBANK(3), .HOLDOFF(HOLD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
        .irq(irq), .vector(vector), .cpu_ack(cpu_ack), .ack_onehot(ack_onehot),
        .bad_code(bad_code),
`ifdef ACK_TIMEOUT_EN
        .timeout(timeout),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        int ev;
        bit ok;
        rst = 1'b1; pa = 1'b1; chan = 4'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({irq, vector, ack_onehot, bad_code, busy} !== 35'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", {irq, vector, ack_onehot, bad_code, busy}); end
        end
        rst = 1'b0;
        q_exp.push_back(4);
        n_cmp++; if ({busy, irq} !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", {busy, irq}); end
        step();
        ev = q_exp.pop_front();
        n_cmp++; if ({irq, vector} !== {1'b1, 5'(ev)}) begin n_err++; $display("FAIL reset_first_req: got %b/%0d want 1/%0d", irq, vector, ev); end
        pa = 1'b0; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_cmp++; if (ack_onehot !== (27'd1 << ev)) begin n_err++; $display("FAIL reset_first_ack: got %h want %h", ack_onehot, 27'd1 << ev); end
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_drain: got busy want idle"); end
    endtask

    task automatic test_basic();
        int ev;
        int n_hi;
        pb = 1'b1; chan = 4'd5;
        q_exp.push_back(14);
        step();
        pb = 1'b0;
        ev = q_exp.pop_front();
        n_hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (irq) n_hi++;
            n_cmp++; if (vector !== 5'(ev)) begin n_err++; $display("FAIL basic_vector: got %0d want %0d", vector, ev); end
            if (i == 2) cpu_ack = 1'b1;
            step();
        end
        cpu_ack = 1'b0;
        n_cmp++; if (n_hi !== 3) begin n_err++; $display("FAIL basic_irq_len: got %0d want 3", n_hi); end
        n_cmp++; if ({irq, ack_onehot} !== {1'b0, 27'd1 << ev}) begin n_err++; $display("FAIL basic_ack: got %b/%h want 0/%h", irq, ack_onehot, 27'd1 << ev); end
        for (int i = 0; i < HOLD; i++) begin
            step();
            n_cmp++; if ({busy, ack_onehot} !== {1'b1, 27'd0}) begin n_err++; $display("FAIL basic_hold: got %b/%h want 1/0", busy, ack_onehot); end
        end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", busy); end
    endtask

    task automatic test_priority();
        logic [2:0] flags [5] = '{3'b111, 3'b001, 3'b011, 3'b010, 3'b100};
        logic [3:0] codes [5] = '{4'd8, 4'd8, 4'd0, 4'd3, 4'd0};
        int         exps  [5] = '{8, 26, 9, 12, 0};
        int ev;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            {pa, pb, pc} = flags[k]; chan = codes[k];
            q_exp.push_back(exps[k]);
            step();
            {pa, pb, pc} = 3'b000;
            ev = q_exp.pop_front();
            n_cmp++; if ({irq, vector} !== {1'b1, 5'(ev)}) begin n_err++; $display("FAIL prio_vector[%0d]: got %b/%0d want 1/%0d", k, irq, vector, ev); end
            cpu_ack = 1'b1;
            step();
            cpu_ack = 1'b0;
            n_cmp++; if (ack_onehot !== (27'd1 << ev)) begin n_err++; $display("FAIL prio_ack[%0d]: got %h want %h", k, ack_onehot, 27'd1 << ev); end
            wait_idle(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL prio_drain[%0d]: got busy want idle", k); end
        end
    endtask

    task automatic test_bad_code();
        int ev;
        bit ok;
        pa = 1'b1; chan = 4'd9;
        step();
        n_cmp++; if ({bad_code, irq, busy} !== 3'b100) begin n_err++; $display("FAIL bad_9: got %b want 100", {bad_code, irq, busy}); end
        chan = 4'd12;
        step();
        step();
        n_cmp++; if ({bad_code, irq, busy} !== 3'b100) begin n_err++; $display("FAIL bad_12: got %b want 100", {bad_code, irq, busy}); end
        chan = 4'd0;
        q_exp.push_back(0);
        step();
        pa = 1'b0;
        ev = q_exp.pop_front();
        n_cmp++; if ({bad_code, irq, vector} !== {2'b11, 5'(ev)}) begin n_err++; $display("FAIL bad_recover: got %b/%b/%0d want 1/1/%0d", bad_code, irq, vector, ev); end
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_cmp++; if (ack_onehot !== (27'd1 << ev)) begin n_err++; $display("FAIL bad_ack: got %h want %h", ack_onehot, 27'd1 << ev); end
        wait_idle(ok);
        n_cmp++; if (!ok || bad_code !== 1'b1) begin n_err++; $display("FAIL bad_sticky: got ok=%b bad=%b want 1/1", ok, bad_code); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bad_code !== 1'b0) begin n_err++; $display("FAIL bad_clear: got %b want 0", bad_code); end
    endtask

    task automatic test_back_to_back();
        int ev;
        int run;
        int last_pulse;
        bit ok;
        pc = 1'b1; chan = 4'd2; cpu_ack = 1'b1;
        for (int k = 0; k < 3; k++) q_exp.push_back(20);
        run = 0;
        last_pulse = -1;
        for (int i = 0; i < 60 && q_exp.size() > 0; i++) begin
            step();
            if (irq) begin
                run++;
                n_cmp++; if (vector !== 5'd20) begin n_err++; $display("FAIL b2b_vector: got %0d want 20", vector); end
            end
            if (ack_onehot !== 27'd0) begin
                ev = q_exp.pop_front();
                n_cmp++; if (ack_onehot !== (27'd1 << ev)) begin n_err++; $display("FAIL b2b_ack: got %h want %h", ack_onehot, 27'd1 << ev); end
                n_cmp++; if (run !== 1) begin n_err++; $display("FAIL b2b_irq_len: got %0d want 1", run); end
                if (last_pulse >= 0) begin
                    n_cmp++; if (i - last_pulse !== 3 + HOLD) begin n_err++; $display("FAIL b2b_period: got %0d want %0d", i - last_pulse, 3 + HOLD); end
                end
                last_pulse = i;
                run = 0;
            end
        end
        n_cmp++; if (q_exp.size() !== 0) begin n_err++; $display("FAIL b2b_count: got %0d pending want 0", q_exp.size()); end
        q_exp.delete();
        pc = 1'b0; cpu_ack = 1'b0;
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_drain: got busy want idle"); end
    endtask

    task automatic test_req_ignore();
        int ev;
        bit ok;
        pa = 1'b1; chan = 4'd1;
        q_exp.push_back(1);
        step();
        ev = q_exp.pop_front();
        pa = 1'b0; pc = 1'b1; chan = 4'd7;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({irq, vector} !== {1'b1, 5'(ev)}) begin n_err++; $display("FAIL ignore_vector: got %b/%0d want 1/%0d", irq, vector, ev); end
            step();
        end
        pc = 1'b0; cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_cmp++; if (ack_onehot !== (27'd1 << ev)) begin n_err++; $display("FAIL ignore_ack: got %h want %h", ack_onehot, 27'd1 << ev); end
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ignore_drain: got busy want idle"); end
    endtask

    task automatic test_rst_in_req();
        pb = 1'b1; chan = 4'd8;
        q_exp.push_back(17);
        step();
        pb = 1'b0;
        n_cmp++; if ({irq, vector} !== {1'b1, 5'(q_exp.pop_front())}) begin n_err++; $display("FAIL rstreq_vector: got %b/%0d want 1/17", irq, vector); end
        rst = 1'b1; cpu_ack = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({irq, busy, ack_onehot} !== 29'd0) begin n_err++; $display("FAIL rstreq_abort: got %b/%b/%h want 0/0/0", irq, busy, ack_onehot); end
        step();
        n_cmp++; if ({irq, busy, ack_onehot} !== 29'd0) begin n_err++; $display("FAIL stray_ack: got %b/%b/%h want 0/0/0", irq, busy, ack_onehot); end
        cpu_ack = 1'b0;
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        int ev;
        int n_irq, n_to, n_ack;
        bit ok;
        pa = 1'b1; chan = 4'd3;
        q_exp.push_back(3);
        step();
        pa = 1'b0;
        ev = q_exp.pop_front();
        n_irq = 0; n_to = 0; n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            if (irq) n_irq++;
            if (timeout) n_to++;
            if (ack_onehot !== 27'd0) n_ack++;
            step();
        end
        n_cmp++; if ({n_irq, n_to, n_ack} !== {TMO, 32'd1, 32'd0}) begin n_err++; $display("FAIL tmo_expire: got irq=%0d to=%0d ack=%0d want %0d/1/0", n_irq, n_to, n_ack, TMO); end
        pa = 1'b1;
        q_exp.push_back(3);
        step();
        pa = 1'b0;
        ev = q_exp.pop_front();
        n_to = 0;
        for (int i = 0; i < TMO; i++) begin
            n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmo_req[%0d]: got %b want 1", i, irq); end
            if (i == TMO - 1) cpu_ack = 1'b1;
            step();
        end
        cpu_ack = 1'b0;
        n_cmp++; if ({timeout, ack_onehot} !== {1'b0, 27'd1 << ev}) begin n_err++; $display("FAIL tmo_ack_wins: got %b/%h want 0/%h", timeout, ack_onehot, 27'd1 << ev); end
        for (int i = 0; i < 6; i++) begin
            if (timeout) n_to++;
            step();
        end
        n_cmp++; if (n_to !== 0) begin n_err++; $display("FAIL tmo_late: got %0d want 0", n_to); end
        wait_idle(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_drain: got busy want idle"); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_bad_code();
        test_back_to_back();
        test_req_ignore();
        test_rst_in_req();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
